// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: default address width, sticky-error bundle, depth helper.
package fifo_pkg;

  localparam int FIFO_W = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int depth(input int w);
    return 2 ** w;
  endfunction

endpackage

// File: rtl/reg_file.sv
// FIFO storage: 2**W x B words, synchronous write, asynchronous read of the head entry.
module reg_file #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [W-1:0] r_addr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller driving reg_file; flags decode from the registered count
// so they are glitch-free and always reflect post-edge state.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int W         = FIFO_W,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_err,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH   = depth(W);
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W+1)'(AF_THRESH);
  localparam logic [W:0] AE_C    = (W+1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range
    $error("fifo_ctrl: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range
    $error("fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [W-1:0] w_ptr, r_ptr;
  logic [W:0]   cnt;
  fifo_err_t    err;
  logic         push_ok, pop_ok;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  assign push_ok = wr & ~full;
  assign pop_ok  = rd & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      err   <= '0;
    end else begin
      if (push_ok) w_ptr <= w_ptr + W'(1);
      if (pop_ok)  r_ptr <= r_ptr + W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (W+1)'(1);
        2'b01:   cnt <= cnt - (W+1)'(1);
        default: cnt <= cnt;
      endcase
      // A fresh error in the same cycle as clr_err must not be lost.
      err.overflow  <= (wr & full)  | (err.overflow  & ~clr_err);
      err.underflow <= (rd & empty) | (err.underflow & ~clr_err);
    end
  end

  assign wr_en     = push_ok;
  assign w_addr    = w_ptr;
  assign r_addr    = r_ptr;
  assign count     = cnt;
  assign overflow  = err.overflow;
  assign underflow = err.underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl + reg_file: directed vector table, mid-cycle reset, then random traffic
// checked against a queue-based FIFO model.
module tb_fifo_ctrl;

  localparam int W = 2;
  localparam int B = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [B-1:0] w_data = '0;
  logic wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [W-1:0] w_addr, r_addr;
  logic [W:0] count;
  logic [B-1:0] r_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.W(W), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  reg_file #(.B(B), .W(W)) u_rf (
    .clk(clk), .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data), .r_data(r_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags are checked as plain arithmetic on the expected occupancy.
  task automatic chk_state(input string tag, input int cnt, input int wa, input int ra,
                           input int ovf, input int unf, input int head);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " empty"}, int'(empty), int'(cnt == 0));
    chk({tag, " full"}, int'(full), int'(cnt == DEPTH));
    chk({tag, " almost_full"}, int'(almost_full), int'(cnt >= AF));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= AE));
    chk({tag, " w_addr"}, int'(w_addr), wa);
    chk({tag, " r_addr"}, int'(r_addr), ra);
    chk({tag, " overflow"}, int'(overflow), ovf);
    chk({tag, " underflow"}, int'(underflow), unf);
    if (cnt != 0) chk({tag, " r_data"}, int'(r_data), head);
  endtask

  typedef struct {
    logic wr, rd, clr;
    logic [7:0] din;
    int cnt, wa, ra, ovf, unf;
    logic [7:0] head;
  } vec_t;

  // Reference model: FIFO contents as a queue, pointers as modular counters.
  logic [7:0] q[$];
  int m_wp, m_rp, m_ovf, m_unf;

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d,
                      input string tag);
    int sz;
    bit push, pop;
    wr = w; rd = r; clr_err = c; w_data = d;
    #1;
    sz = q.size();
    push = w && (sz < DEPTH);
    pop  = r && (sz > 0);
    chk({tag, " wr_en"}, int'(wr_en), int'(push));
    @(posedge clk);
    #1;
    m_ovf = (w && sz == DEPTH) ? 1 : (c ? 0 : m_ovf);
    m_unf = (r && sz == 0) ? 1 : (c ? 0 : m_unf);
    if (pop) begin
      void'(q.pop_front());
      m_rp = (m_rp + 1) % DEPTH;
    end
    if (push) begin
      q.push_back(d);
      m_wp = (m_wp + 1) % DEPTH;
    end
    chk_state(tag, q.size(), m_wp, m_rp, m_ovf, m_unf, (q.size() != 0) ? int'(q[0]) : 0);
  endtask

  vec_t vecs[$];

  initial begin
    int prev_cnt;
    // wr rd clr din | cnt wa ra ovf unf head
    vecs = '{
      '{0,0,0,8'h00, 0,0,0,0,0, 8'h00},
      '{1,0,0,8'h11, 1,1,0,0,0, 8'h11},
      '{1,0,0,8'h22, 2,2,0,0,0, 8'h11},
      '{1,0,0,8'h33, 3,3,0,0,0, 8'h11},
      '{1,0,0,8'h44, 4,0,0,0,0, 8'h11},
      '{1,0,0,8'h55, 4,0,0,1,0, 8'h11},
      '{0,0,0,8'h00, 4,0,0,1,0, 8'h11},
      '{1,0,1,8'h66, 4,0,0,1,0, 8'h11},
      '{0,0,1,8'h00, 4,0,0,0,0, 8'h11},
      '{0,1,0,8'h00, 3,0,1,0,0, 8'h22},
      '{0,1,0,8'h00, 2,0,2,0,0, 8'h33},
      '{0,1,0,8'h00, 1,0,3,0,0, 8'h44},
      '{0,1,0,8'h00, 0,0,0,0,0, 8'h00},
      '{0,1,0,8'h00, 0,0,0,0,1, 8'h00},
      '{0,0,1,8'h00, 0,0,0,0,0, 8'h00},
      '{1,0,0,8'h77, 1,1,0,0,0, 8'h77},
      '{1,0,0,8'h88, 2,2,0,0,0, 8'h77},
      '{1,1,0,8'h99, 2,3,1,0,0, 8'h88},
      '{0,1,0,8'h00, 1,3,2,0,0, 8'h99},
      '{0,1,0,8'h00, 0,3,3,0,0, 8'h00},
      '{1,1,0,8'hAA, 1,0,3,0,1, 8'hAA},
      '{0,0,1,8'h00, 1,0,3,0,0, 8'hAA},
      '{1,0,0,8'hBB, 2,1,3,0,0, 8'hAA},
      '{1,0,0,8'hCC, 3,2,3,0,0, 8'hAA},
      '{1,0,0,8'hDD, 4,3,3,0,0, 8'hAA},
      '{1,1,0,8'hEE, 3,3,0,1,0, 8'hBB}
    };

    #12;
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    chk("reset wr_en", int'(wr_en), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    prev_cnt = 0;
    foreach (vecs[i]) begin
      wr = vecs[i].wr; rd = vecs[i].rd; clr_err = vecs[i].clr; w_data = vecs[i].din;
      #1;
      chk($sformatf("vec%0d wr_en", i), int'(wr_en), int'(vecs[i].wr && prev_cnt != DEPTH));
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wa, vecs[i].ra,
                vecs[i].ovf, vecs[i].unf, vecs[i].head);
      prev_cnt = vecs[i].cnt;
    end

    // Table leaves count=3; reset asynchronously between edges.
    wr = 0; rd = 0; clr_err = 0;
    #2 reset = 1'b1;
    #1;
    chk_state("async_reset", 0, 0, 0, 0, 0, 0);
    chk("async_reset wr_en", int'(wr_en), 0);
    reset = 1'b0;
    model_reset();
    step(1, 0, 0, 8'hA5, "post_reset push");

    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 8'(8'h10 + i), $sformatf("pair%0d", i));

    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 8);
      step(w, r, c, 8'($urandom), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
